// File: rtl/sd_rx_fifo_pack.sv
// SD receive buffer: packs nibbles MSB-first into 32-bit words and queues them in a FWFT FIFO.
module sd_rx_fifo_pack #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned ADR_SIZE = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [3:0]          d,
    input  logic                wr,
    input  logic                clr,
    output logic [31:0]         q,
    input  logic                rd,
    output logic                full,
    output logic                empty,
    output logic                overrun,
    output logic                partial,
    output logic [ADR_SIZE-1:0] mem_level
);

    localparam int unsigned IDX_W  = ADR_SIZE - 1;
    localparam int unsigned WORD_W = 32;

    logic [WORD_W-1:0]   mem [DEPTH];
    logic [WORD_W-1:0]   sreg;
    logic [2:0]          ncnt;
    logic [ADR_SIZE-1:0] wptr;
    logic [ADR_SIZE-1:0] rptr;
    logic                ovr_q;

    logic                word_done_c;
    logic                pop_c;
    logic                push_c;
    logic                drop_c;
    logic [WORD_W-1:0]   push_word_c;
    logic                unused_sreg_c;

    // Completion, acceptance and flag decode; a same-cycle pop frees a slot for the push
    always_comb begin
        word_done_c = 1'b0;
        pop_c       = 1'b0;
        push_c      = 1'b0;
        drop_c      = 1'b0;
        push_word_c = {sreg[27:0], d};
        empty       = (wptr == rptr);
        full        = (wptr[IDX_W-1:0] == rptr[IDX_W-1:0]) &&
                      (wptr[ADR_SIZE-1] != rptr[ADR_SIZE-1]);
        mem_level   = wptr - rptr;
        partial     = (ncnt != 3'd0);
        if (!clr) begin
            word_done_c = wr && (ncnt == 3'd7);
            pop_c       = rd && !empty;
            push_c      = word_done_c && (!full || pop_c);
            drop_c      = word_done_c && !push_c;
        end
    end

    // Top nibble of the shift register has already been shifted out by completion time
    assign unused_sreg_c = ^sreg[31:28];

    assign q       = mem[rptr[IDX_W-1:0]];
    assign overrun = ovr_q;

    // Packer shift register and nibble counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg <= '0;
            ncnt <= 3'd0;
        end else if (clr) begin
            ncnt <= 3'd0;
        end else if (wr) begin
            sreg <= {sreg[27:0], d};
            ncnt <= ncnt + 3'd1;
        end
    end

    // FIFO pointers and sticky overrun flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            ovr_q <= 1'b0;
        end else if (clr) begin
            wptr  <= '0;
            rptr  <= '0;
            ovr_q <= 1'b0;
        end else begin
            if (push_c) wptr <= wptr + ADR_SIZE'(1);
            if (pop_c)  rptr <= rptr + ADR_SIZE'(1);
            if (drop_c) ovr_q <= 1'b1;
        end
    end

    // Word storage, written only on an accepted push
    always_ff @(posedge clk) begin
        if (push_c) mem[wptr[IDX_W-1:0]] <= push_word_c;
    end

endmodule

// File: tb/tb_sd_rx_fifo_pack.sv
// Directed plus random bench for sd_rx_fifo_pack against a queue-based reference model.
module tb_sd_rx_fifo_pack;

    localparam int unsigned DEPTH    = 8;
    localparam int unsigned ADR_SIZE = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [3:0]          d;
    logic                wr, clr, rd;
    logic [31:0]         q;
    logic                full, empty, overrun, partial;
    logic [ADR_SIZE-1:0] mem_level;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state
    logic [31:0] fq[$];
    int          nq[$];
    logic        m_ovr;
    bit          saw_full;

    sd_rx_fifo_pack #(.DEPTH(DEPTH), .ADR_SIZE(ADR_SIZE)) dut (
        .clk(clk), .rst_n(rst_n), .d(d), .wr(wr), .clr(clr), .q(q), .rd(rd),
        .full(full), .empty(empty), .overrun(overrun), .partial(partial),
        .mem_level(mem_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        fq.delete();
        nq.delete();
        m_ovr = 1'b0;
    endtask

    // Behavioural update for one rising edge
    task automatic model_edge(input logic w, input logic [3:0] dd, input logic r, input logic c);
        logic        pop, do_push, was_full;
        logic [31:0] word;
        if (c) begin
            model_reset();
            return;
        end
        pop      = r && (fq.size() > 0);
        was_full = (fq.size() == DEPTH);
        do_push  = 1'b0;
        word     = '0;
        if (w) begin
            nq.push_back(int'(dd));
            if (nq.size() == 8) begin
                foreach (nq[i]) word = word * 32'd16 + 32'(nq[i]);
                nq.delete();
                if (!was_full || pop) do_push = 1'b1;
                else m_ovr = 1'b1;
            end
        end
        if (pop) void'(fq.pop_front());
        if (do_push) fq.push_back(word);
    endtask

    task automatic check_all();
        check("empty",     32'(empty),     32'(fq.size() == 0));
        check("full",      32'(full),      32'(fq.size() == DEPTH));
        check("mem_level", 32'(mem_level), 32'(fq.size()));
        check("partial",   32'(partial),   32'(nq.size() != 0));
        check("overrun",   32'(overrun),   32'(m_ovr));
        if (fq.size() != 0) check("q", q, fq[0]);
        if (full) saw_full = 1'b1;
    endtask

    // One clock: apply inputs, clock, update model, sample 1 time unit after the edge
    task automatic step(input logic w, input logic [3:0] dd, input logic r, input logic c);
        wr = w; d = dd; rd = r; clr = c;
        @(posedge clk);
        model_edge(w, dd, r, c);
        #1;
        wr = 1'b0; rd = 1'b0; clr = 1'b0; d = 4'h0;
        check_all();
    endtask

    // Feed one word MSB nibble first; rd only alongside the last nibble
    task automatic push_word(input logic [31:0] w, input logic rd_last);
        logic [31:0] t;
        t = w;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, t[31:28], (i == 7) ? rd_last : 1'b0, 1'b0);
            t = t << 4;
        end
    endtask

    task automatic pop_one();
        step(1'b0, 4'h0, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        check("rst_partial", 32'(partial), 32'd0);
        check("rst_empty",   32'(empty),   32'd1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] w;
        logic        r;
        wr = 1'b0; rd = 1'b0; clr = 1'b0; d = 4'h0; rst_n = 1'b1;
        saw_full = 1'b0;
        model_reset();

        // reset state
        do_reset();
        check("rst_full",    32'(full),      32'd0);
        check("rst_level",   32'(mem_level), 32'd0);
        check("rst_overrun", 32'(overrun),   32'd0);

        // nibbles 1..8 back to back
        for (int i = 1; i <= 8; i++) step(1'b1, 4'(i), 1'b0, 1'b0);
        check("word_12345678", q, 32'h12345678);
        check("level_1", 32'(mem_level), 32'd1);
        pop_one();

        // gapped nibbles with idle cycles
        begin
            logic [3:0] gn [8];
            gn = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0, 4'h1};
            for (int i = 0; i < 8; i++) begin
                step(1'b1, gn[i], 1'b0, 1'b0);
                if (i < 7) begin
                    step(1'b0, 4'h0, 1'b0, 1'b0);
                    step(1'b0, 4'h0, 1'b0, 1'b0);
                    check("gap_partial", 32'(partial), 32'd1);
                end
            end
        end
        check("word_abcdef01", q, 32'hABCDEF01);
        pop_one();

        // fill, overflow by one, then flush
        for (int k = 0; k < 8; k++) push_word({4'h0, 4'(k), 4'h0, 4'(k), 4'h0, 4'(k), 4'h0, 4'(k)}, 1'b0);
        check("fill_full",  32'(full),      32'd1);
        check("fill_level", 32'(mem_level), 32'd8);
        push_word(32'h08080808, 1'b0);
        check("ovf_overrun", 32'(overrun), 32'd1);
        check("ovf_head",    q,            32'h00000000);
        check("ovf_level",   32'(mem_level), 32'd8);
        step(1'b0, 4'h0, 1'b0, 1'b1);
        check("clr_empty",   32'(empty),   32'd1);
        check("clr_overrun", 32'(overrun), 32'd0);

        // full FIFO, 9th word completes alongside a read
        for (int k = 1; k <= 8; k++) push_word(32'h11111111 * 32'(k), 1'b0);
        push_word(32'h99999999, 1'b1);
        check("fullrd_full",    32'(full),    32'd1);
        check("fullrd_overrun", 32'(overrun), 32'd0);
        check("fullrd_head",    q,            32'h22222222);
        for (int k = 0; k < 8; k++) pop_one();
        check("fullrd_drained", 32'(empty), 32'd1);

        // wrap-around streaming with immediate pops
        saw_full = 1'b0;
        for (int k = 0; k < 20; k++) begin
            w = $urandom;
            for (int i = 0; i < 8; i++) begin
                step(1'b1, w[31:28], fq.size() > 0, 1'b0);
                w = w << 4;
            end
        end
        pop_one();
        check("wrap_never_full", 32'(saw_full), 32'd0);
        check("wrap_empty",      32'(empty),    32'd1);

        // reset mid-word with data stored
        for (int k = 0; k < 3; k++) push_word($urandom, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 4'(i + 3), 1'b0, 1'b0);
        do_reset();
        push_word(32'hCAFE1234, 1'b0);
        check("post_rst_word", q, 32'hCAFE1234);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 3) == 0);
            step($urandom_range(0, 3) != 0, 4'($urandom), r, $urandom_range(0, 99) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
